// File: rtl/mdu_ctrl_if.sv
// E-stage / hazard-side signal bundle for the multiply/divide sequencer.
// The E stage and hazard processor drive the master side; mdu_ctrl is the slave.
interface mdu_ctrl_if;
    logic [3:0]  E_mdOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_useMd;
    logic        busy;
    logic        stallMd;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdRes;

    modport master (
        output E_mdOp, E_A, E_B, D_useMd,
        input  busy, stallMd, HI, LO, mdRes
    );

    modport slave (
        input  E_mdOp, E_A, E_B, D_useMd,
        output busy, stallMd, HI, LO, mdRes
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models mult/div latency with a busy
// down-counter and requests D-stage stalls for HI/LO-dependent instructions.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   md
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_phi;
    logic [31:0] r_plo;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    logic        w_is_arith;
    logic        w_start;
    logic        w_div_ok;
    logic        w_sdiv_ovf;
    logic [31:0] w_b_safe;
    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic [31:0] w_squo;
    logic [31:0] w_srem;
    logic [31:0] w_uquo;
    logic [31:0] w_urem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_is_arith = (md.E_mdOp >= 4'd1) && (md.E_mdOp <= 4'd4);
    assign w_start    = w_is_arith && (r_state == S_IDLE);

    // Divisor is forced non-zero so the dividers never produce X; a zero
    // divisor keeps the current HI/LO as the "result" instead.
    assign w_div_ok   = (md.E_B != '0);
    assign w_b_safe   = w_div_ok ? md.E_B : 32'd1;
    // INT_MIN / -1 overflows the signed divider; pin it to the wrapped result.
    assign w_sdiv_ovf = (md.E_A == 32'h8000_0000) && (md.E_B == '1);

    assign w_smul = {{32{md.E_A[31]}}, md.E_A} * {{32{md.E_B[31]}}, md.E_B};
    assign w_umul = {32'd0, md.E_A} * {32'd0, md.E_B};
    assign w_squo = w_sdiv_ovf ? 32'h8000_0000 : 32'($signed(md.E_A) / $signed(w_b_safe));
    assign w_srem = w_sdiv_ovf ? 32'd0 : 32'($signed(md.E_A) % $signed(w_b_safe));
    assign w_uquo = md.E_A / w_b_safe;
    assign w_urem = md.E_A % w_b_safe;

    // Select the result that will be parked in the pending registers
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (md.E_mdOp)
            4'd1: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
            end
            4'd2: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
            end
            4'd3: begin
                if (w_div_ok) begin
                    w_res_hi = w_srem;
                    w_res_lo = w_squo;
                end
            end
            4'd4: begin
                if (w_div_ok) begin
                    w_res_hi = w_urem;
                    w_res_lo = w_uquo;
                end
            end
            default: ;
        endcase
    end

    // State, counter and HI/LO/pending registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_start) begin
                r_phi <= w_res_hi;
                r_plo <= w_res_lo;
            end
        end
    end

    // Next state: start/countdown, mthi/mtlo writes, commit of pending result
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = (md.E_mdOp <= 4'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                end else if (md.E_mdOp == 4'd5) begin
                    w_hi_nxt = md.E_A;
                end else if (md.E_mdOp == 4'd6) begin
                    w_lo_nxt = md.E_A;
                end
            end
            S_BUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = r_phi;
                    w_lo_nxt    = r_plo;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: busy flag, stall request and E-stage HI/LO read mux
    always_comb begin
        md.busy    = (r_state == S_BUSY);
        md.stallMd = md.D_useMd && ((r_state == S_BUSY) || w_is_arith);
        md.HI      = r_hi;
        md.LO      = r_lo;
        case (md.E_mdOp)
            4'd7:    md.mdRes = r_hi;
            4'd8:    md.mdRes = r_lo;
            default: md.mdRes = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed ops push expected HI/LO and busy
// length into a scoreboard; a monitor pops and checks whenever busy falls.
module tb_mdu_ctrl;

    logic clk;
    logic reset;

    mdu_ctrl_if mif ();

    mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (mif)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive after the rising edge, return at the falling edge
    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic d, input logic rst = 1'b0);
        @(posedge clk);
        #1;
        reset       = rst;
        mif.E_mdOp  = op;
        mif.E_A     = a;
        mif.E_B     = b;
        mif.D_useMd = d;
        @(negedge clk);
    endtask

    // Start an op, push its expectation and hold E idle through the busy window
    task automatic run_busy(input string nm, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic d, input logic [31:0] ehi,
                            input logic [31:0] elo, input int unsigned n);
        exp_t e;
        e.name = nm; e.hi = ehi; e.lo = elo; e.cycles = n;
        sb.push_back(e);
        cyc(op, a, b, d);
        chk({nm, "_stall_start"}, {31'd0, mif.stallMd}, {31'd0, d});
        for (int unsigned i = 0; i < n; i++) begin
            cyc(4'd0, 32'd0, 32'd0, d);
            chk({nm, "_stall_busy"}, {31'd0, mif.stallMd}, {31'd0, d});
        end
    endtask

    // Monitor: checks stability during busy and the committed result on busy fall
    initial begin : monitor
        logic        prev_busy;
        int unsigned busy_len;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;
        exp_t        e;
        prev_busy = 1'b0;
        busy_len  = 0;
        hold_hi   = '0;
        hold_lo   = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                prev_busy = 1'b0;
                busy_len  = 0;
            end else begin
                if (mif.busy === 1'b1) begin
                    if (!prev_busy) begin
                        hold_hi  = mif.HI;
                        hold_lo  = mif.LO;
                        busy_len = 0;
                    end else begin
                        chk("hi_stable_busy", mif.HI, hold_hi);
                        chk("lo_stable_busy", mif.LO, hold_lo);
                    end
                    busy_len++;
                    checks++;
                    if (mif.E_mdOp >= 4'd1 && mif.E_mdOp <= 4'd6) begin
                        failures++;
                        $display("FAIL protocol: op %0d issued while busy", mif.E_mdOp);
                    end
                end else if (prev_busy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result: HI %h LO %h with empty scoreboard", mif.HI, mif.LO);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_busy_len"}, busy_len, e.cycles);
                        chk({e.name, "_HI"}, mif.HI, e.hi);
                        chk({e.name, "_LO"}, mif.LO, e.lo);
                    end
                end
                prev_busy = mif.busy;
            end
        end
    end

    initial begin : stim
        int unsigned waited;
        reset       = 1'b1;
        mif.E_mdOp  = '0;
        mif.E_A     = '0;
        mif.E_B     = '0;
        mif.D_useMd = 1'b0;

        // Reset: stall still follows a start-class op combinationally
        cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(4'd1, 32'd3, 32'd3, 1'b1, 1'b1);
        chk("stall_in_reset", {31'd0, mif.stallMd}, 32'd1);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_HI", mif.HI, 32'd0);
        chk("rst_LO", mif.LO, 32'd0);
        chk("rst_mdRes", mif.mdRes, 32'd0);
        chk("rst_stall", {31'd0, mif.stallMd}, 32'd0);

        // mult -3*7 with a dependent instruction in D; stall drops at N+6
        run_busy("mult_neg", 4'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        chk("mult_stall_release", {31'd0, mif.stallMd}, 32'd0);

        // No MD instruction in D: never stall; back-to-back divu on first idle cycle
        run_busy("mult_pos", 4'd1, 32'd5, 32'd6, 1'b0, 32'd0, 32'd30, 5);
        run_busy("divu_17_5", 4'd4, 32'd17, 32'd5, 1'b0, 32'd2, 32'd3, 10);
        run_busy("div_m7_2", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);

        // mthi followed by mfhi/mflo in E
        cyc(4'd5, 32'h1234_5678, 32'd0, 1'b1);
        chk("mthi_stall", {31'd0, mif.stallMd}, 32'd0);
        cyc(4'd7, 32'd0, 32'd0, 1'b1);
        chk("mthi_HI", mif.HI, 32'h1234_5678);
        chk("mfhi_mdRes", mif.mdRes, 32'h1234_5678);
        cyc(4'd8, 32'd0, 32'd0, 1'b0);
        chk("mflo_mdRes", mif.mdRes, 32'hFFFF_FFFD);
        cyc(4'd0, 32'd0, 32'd0, 1'b0);
        chk("none_mdRes", mif.mdRes, 32'd0);

        // Divide by zero keeps HI/LO from mtlo/mthi
        cyc(4'd6, 32'h0000_00AA, 32'd0, 1'b0);
        cyc(4'd5, 32'h0000_00BB, 32'd0, 1'b0);
        chk("mtlo_LO", mif.LO, 32'h0000_00AA);
        run_busy("div_by0", 4'd3, 32'h55, 32'd0, 1'b0, 32'h0000_00BB, 32'h0000_00AA, 10);

        // Reset during the 4th busy cycle of a div aborts it
        cyc(4'd3, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 3; i++) cyc(4'd0, 32'd0, 32'd0, 1'b0);
        cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(4'd0, 32'd0, 32'd0, 1'b1);
        chk("abort_busy", {31'd0, mif.busy}, 32'd0);
        chk("abort_HI", mif.HI, 32'd0);
        chk("abort_LO", mif.LO, 32'd0);
        chk("abort_stall", {31'd0, mif.stallMd}, 32'd0);

        run_busy("multu_max", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd1, 32'hFFFF_FFFE, 5);
        run_busy("div_7_m2", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD, 10);
        run_busy("divu_big", 4'd4, 32'hFFFF_FFFF, 32'h10, 1'b0, 32'hF, 32'h0FFF_FFFF, 10);

        // Drain: every pushed expectation must be consumed within a bounded window
        waited = 0;
        while (sb.size() != 0 && waited < 50) begin
            cyc(4'd0, 32'd0, 32'd0, 1'b0);
            waited++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
        end
        cyc(4'd0, 32'd0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
